// File: rtl/mac_pipeline_arbiter.sv
// mac_pipeline_arbiter: round-robin sharing of one stallable 8-input MAC pipeline among NUM_REQ requesters.
// Define MAC_PIPELINE_ARBITER_STATS_EN to add per-requester accept and stall-cycle counters.
module simple_pipeline_with_en #(
  parameter int WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic                  valid_in,
  input  logic [7:0][WIDTH-1:0] in,
  output logic                  valid_out,
  output logic [WIDTH-1:0]      out
);
  logic [3:0]            v;
  logic [3:0][WIDTH-1:0] p;
  logic [1:0][WIDTH-1:0] s2;
  logic [WIDTH-1:0]      s3, s4;
  always_ff @(posedge clk) begin
    if (rst) begin
      v  <= '0;
      p  <= '0;
      s2 <= '0;
      s3 <= '0;
      s4 <= '0;
    end else if (en) begin
      v <= {v[2:0], valid_in};
      for (int j = 0; j < 4; j++) p[j] <= in[2*j] * in[2*j+1];
      s2[0] <= p[0] + p[1];
      s2[1] <= p[2] + p[3];
      s3    <= s2[0] + s2[1];
      s4    <= s3;
    end
  end
  assign valid_out = v[3];
  assign out       = s4;
endmodule

module mac_pipeline_arbiter #(
  parameter int WIDTH   = 16,
  parameter int NUM_REQ = 4
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [NUM_REQ-1:0]              req_valid,
  output logic [NUM_REQ-1:0]              req_ready,
  input  logic [NUM_REQ-1:0][7:0][WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]              resp_valid,
  input  logic [NUM_REQ-1:0]              resp_ready,
  output logic [WIDTH-1:0]                resp_data,
`ifdef MAC_PIPELINE_ARBITER_STATS_EN
  input  logic                            stat_clr,
  output logic [NUM_REQ-1:0][31:0]        stat_ops,
  output logic [31:0]                     stat_stall,
`endif
  output logic                            busy
);
  localparam int LATENCY = 4;
  localparam int TAG_W   = $clog2(NUM_REQ);
  localparam logic [TAG_W:0]   NR   = (TAG_W+1)'(NUM_REQ);
  localparam logic [TAG_W-1:0] LAST = TAG_W'(NUM_REQ - 1);

  logic [TAG_W-1:0]              rr_ptr, g;
  logic [LATENCY-1:0]            tv;
  logic [LATENCY-1:0][TAG_W-1:0] tag;
  logic                          stall, en, acc, pipe_valid_out;
  logic [7:0][WIDTH-1:0]         din;

  function automatic logic [TAG_W-1:0] wrap(input logic [TAG_W:0] s);
    return s >= NR ? TAG_W'(s - NR) : TAG_W'(s);
  endfunction

  assign stall = pipe_valid_out & ~resp_ready[tag[LATENCY-1]];
  assign en    = ~stall;
  assign acc   = en & |req_valid;

  // Scan downward so the requester closest to rr_ptr is the last (winning) assignment.
  always_comb begin
    g = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--)
      if (req_valid[wrap({1'b0, rr_ptr} + (TAG_W+1)'(k))]) g = wrap({1'b0, rr_ptr} + (TAG_W+1)'(k));
  end

  assign req_ready  = acc ? NUM_REQ'(1) << g : '0;
  assign din        = acc ? req_data[g] : '0;
  assign resp_valid = pipe_valid_out ? NUM_REQ'(1) << tag[LATENCY-1] : '0;
  assign busy       = |tv;

  simple_pipeline_with_en #(.WIDTH(WIDTH)) u_pipe (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .valid_in (acc),
    .in       (din),
    .valid_out(pipe_valid_out),
    .out      (resp_data)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr <= '0;
      tv     <= '0;
      tag    <= '0;
    end else if (en) begin
      tv  <= {tv[LATENCY-2:0], acc};
      tag <= {tag[LATENCY-2:0], g};
      if (acc) rr_ptr <= g == LAST ? '0 : g + 1'b1;
    end
  end

`ifdef MAC_PIPELINE_ARBITER_STATS_EN
  always_ff @(posedge clk) begin
    if (rst || stat_clr) begin
      stat_ops   <= '0;
      stat_stall <= '0;
    end else begin
      if (stall && stat_stall != '1) stat_stall <= stat_stall + 1'b1;
      if (acc && stat_ops[g] != '1) stat_ops[g] <= stat_ops[g] + 1'b1;
    end
  end
`endif
endmodule

// File: doc/mac_pipeline_arbiter.md
Name: mac_pipeline_arbiter

Overview:
- Shares one simple_pipeline_with_en instance (8-input multiply-accumulate, 4-cycle latency, global stall on en=0) between NUM_REQ requesters.
- Requester side: round-robin arbitration with per-requester valid/ready handshakes.
- Tracking: each accepted operation carries a requester tag alongside the pipeline; the result returns only to the originating requester.
- Backpressure: the pipeline stalls when the destination of the head result is not ready.
- Placement: between multiple client engines and the shared MAC datapath.

Parameters:
- WIDTH, 16, data width of operands and result; passed to the pipeline.
- NUM_REQ, 4, number of requesters; legal range 2..16.
- Derived (localparam, not overridable): LATENCY = 4 (pipeline latency); TAG_W = $clog2(NUM_REQ).

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- req_valid  in  NUM_REQ  requester i presents an operation
- req_ready  out  NUM_REQ  requester i's operation accepted this cycle
- req_data  in  [NUM_REQ][8] x WIDTH  eight operands per requester
- resp_valid  out  NUM_REQ  result for requester i present on resp_data
- resp_ready  in  NUM_REQ  requester i can take its result
- resp_data  out  WIDTH  pipeline result, shared by all requesters
- busy  out  1  any valid operation in flight

Behaviour:
- Interface rule: one clock, clk. Reset rst is synchronous, active-high, and is also wired to the pipeline's rst.
- Stall:
  - stall = pipe_valid_out & ~resp_ready[tag_out]; pipeline en = ~stall.
  - The whole pipeline freezes, including bubbles.
- Arbitration:
  - When en=1, grant goes to the first i with req_valid[i]=1, searching from rr_ptr upward with wrap.
  - req_ready is one-hot: req_ready[g] = en & req_valid[g]. All req_ready are 0 when stall=1 or no requests are pending.
- Accept:
  - On accept, the pipeline in[k] = req_data[g][k] and valid_in=1. Otherwise valid_in=0 and in is don't-care (drive 0).
  - rr_ptr <= (g+1) mod NUM_REQ on accept only. It holds otherwise, so an idle requester never loses its turn.
- Tag line:
  - LATENCY-deep shift register of TAG_W tags plus valid bits, shifted only when en=1, in lockstep with the pipeline valid chain.
  - tag_out is the last stage.
- Response:
  - resp_data = pipeline out.
  - resp_valid[i] = pipe_valid_out & (tag_out==i); at most one bit is high.
  - A response completes when resp_valid[i] & resp_ready[i].
  - resp_data and resp_valid are held stable while stalled.
- Latency:
  - An operation accepted at rising edge t presents resp_valid at edge t+4 when no stalls occur; each stall cycle adds one.
  - Throughput is 1 op/cycle with no stalls.
- Arithmetic: out = sum over j=0..3 of in[2j]*in[2j+1]. Products and sums truncate modulo 2^WIDTH.
- busy = OR of all tag-line valid bits.
- Reset (including mid-operation):
  - All in-flight ops are discarded (tag valids 0, pipeline registers 0).
  - rr_ptr=0; req_ready=0; resp_valid=0; resp_data=0; busy=0.
  - Requesters must re-issue any dropped operation.
- Simultaneous events:
  - Accept in the same cycle the head result completes: both proceed.
  - Stall in a cycle where req_valid is high: no accept, rr_ptr unchanged.
  - NUM_REQ not a power of two: ptr wrap uses modulo; unused tag codes never occur.

Optional Feature:
- Macro: MAC_PIPELINE_ARBITER_STATS_EN.
- When defined:
  - Adds output ports stat_ops[NUM_REQ] x 32 (accept count per requester) and stat_stall x 32 (cycles with stall=1).
  - Adds input stat_clr: synchronous clear with priority over increment.
  - Counters saturate at 2^32-1 and reset to 0.
- When undefined: these ports and counters are absent. Functional behaviour is otherwise identical.

Test Plan:
- Single op: req_valid[0]=1, operands 1..8, all resp_ready=1 -> req_ready[0] pulses one cycle; resp_valid=4'b0001 with resp_data=100 exactly 4 cycles later; busy high 4 cycles.
- Round robin: all four requesters valid continuously, requester i operands all i+1 -> accept order 0,1,2,3,0,...; results 4,16,36,64 repeating on resp_valid bits 0,1,2,3, one per cycle.
- Backpressure: as above, but resp_ready[1]=0 for 3 cycles when the tag-1 result is at the head -> all req_ready=0 and resp_data=16 held for 3 cycles; no result lost, reordered, or duplicated.
- Fairness: requesters 0 and 2 always valid, 1 and 3 idle -> grants alternate 0,2,0,2; rr_ptr never starves requester 2.
- Overflow (WIDTH=16): all operands 16'hFFFF -> resp_data = 4*(0xFFFE0001 mod 2^16) mod 2^16 = 16'h0004.
- Mid-flight reset: accept 3 ops, assert rst 1 cycle -> next cycle resp_valid=0, busy=0, resp_data=0; the next accept goes to requester 0 and completes normally.
